median_window_fifo: RTL

//  Sliding-window sample buffer upstream of the 2:1 data mux in the L2 single-comparator median path.

---
 rtl/median_window_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/median_window_fifo.sv
// median_window_fifo: DEPTH-sample circular window that emits (newest, evicted) pairs for the median mux.
// Optional synchronous window flush is enabled by defining MWF_FLUSH_EN.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

module median_window_fifo #(
    parameter int DEPTH = 9,
    parameter int PTR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [`DATA_LENGTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [`DATA_LENGTH-1:0] new_data,
    output logic [`DATA_LENGTH-1:0] old_data,
    output logic                    evict_vld,
    output logic [PTR_W-1:0]        level
`ifdef MWF_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    logic [`DATA_LENGTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]        wptr_r;
    logic [PTR_W-1:0]        wptr_nxt_s;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    accept_s;
    logic                    flush_s;

`ifdef MWF_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Ready/accept handshake: a held pair blocks new samples until consumed.
    always_comb begin
        in_ready = 1'b0;
        accept_s = 1'b0;
        in_ready = !out_valid || out_ready;
        accept_s = in_valid && in_ready;
    end

    // Next state and write pointer; pointer wraps at DEPTH-1, not at a power of two.
    always_comb begin
        state_nxt_s = state_r;
        wptr_nxt_s  = wptr_r;
        if (flush_s) begin
            state_nxt_s = FILL;
            wptr_nxt_s  = {PTR_W{1'b0}};
        end else if (accept_s) begin
            if (wptr_r == LAST_IDX) begin
                wptr_nxt_s = {PTR_W{1'b0}};
            end else begin
                wptr_nxt_s = wptr_r + PTR_W'(1);
            end
            case (state_r)
                FILL: begin
                    if (level == LAST_IDX) begin
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end
                FULL:    state_nxt_s = FULL;
                default: state_nxt_s = FILL;
            endcase
        end else begin
            state_nxt_s = state_r;
            wptr_nxt_s  = wptr_r;
        end
    end

    // State, pointer, level and the registered output pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= FILL;
            wptr_r    <= {PTR_W{1'b0}};
            level     <= {PTR_W{1'b0}};
            out_valid <= 1'b0;
            new_data  <= {`DATA_LENGTH{1'b0}};
            old_data  <= {`DATA_LENGTH{1'b0}};
            evict_vld <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wptr_r  <= wptr_nxt_s;
            if (flush_s) begin
                // Data registers deliberately keep their values; only validity is dropped.
                level     <= {PTR_W{1'b0}};
                out_valid <= 1'b0;
            end else if (accept_s) begin
                out_valid <= 1'b1;
                new_data  <= in_data;
                case (state_r)
                    FULL: begin
                        // Non-blocking read sees the pre-write contents of the slot being replaced.
                        old_data  <= mem_r[wptr_r[AW-1:0]];
                        evict_vld <= 1'b1;
                    end
                    default: begin
                        old_data  <= {`DATA_LENGTH{1'b0}};
                        evict_vld <= 1'b0;
                        level     <= level + PTR_W'(1);
                    end
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sample storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_s && accept_s) begin
            mem_r[wptr_r[AW-1:0]] <= in_data;
        end
    end

endmodule
